// File: rtl/mips_mem_responder_if.sv
// mips_mem_responder_if: fetch and data request/ack bus between the pipeline and the memory responder
interface mips_mem_responder_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        err;
  logic        busy;
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, err, busy
  );
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, err, busy
  );
endinterface

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: wait-stated word memory serving fetch and data ports, data first
module mips_mem_responder #(
  parameter int DEPTH = 1024,
  parameter int WAIT = 2
) (
  input logic clk1,
  input logic rst,
  mips_mem_responder_if.slave bus
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAITS, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic dm_q, dm_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic if_ack_q, if_ack_d, dm_ack_q, dm_ack_d, err_q, err_d;
  logic [31:0] mem [DEPTH];
  logic in_range, access, mem_we;
  logic [31:0] rd;
  assign in_range = addr_q < 32'(DEPTH);
  assign access = state_q == ACCESS;
  assign mem_we = !rst && access && we_q && in_range;
  assign rd = in_range ? mem[addr_q[AW-1:0]] : 32'h0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dm_d = dm_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d = access && !dm_q;
    dm_ack_d = access && dm_q;
    err_d = access && !in_range;
    if (state_q == IDLE && (bus.dm_req || bus.if_req)) begin
      dm_d = bus.dm_req;
      we_d = bus.dm_req && bus.dm_we;
      addr_d = bus.dm_req ? bus.dm_addr : bus.if_addr;
      wdata_d = bus.dm_wdata;
      cnt_d = 4'(WAIT);
      state_d = WAIT > 0 ? WAITS : ACCESS;
    end
    if (state_q == WAITS) begin
      cnt_d = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? ACCESS : WAITS;
    end
    if (access) begin
      if_rdata_d = !dm_q ? rd : if_rdata_q;
      dm_rdata_d = dm_q && !we_q ? rd : dm_rdata_q;
      state_d = DONE;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dm_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dm_q <= dm_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q <= if_ack_d;
      dm_ack_q <= dm_ack_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk1) if (mem_we) mem[addr_q[AW-1:0]] <= wdata_q;
  assign bus.if_ack = if_ack_q;
  assign bus.dm_ack = dm_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.err = err_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: table, sequence and random checks against a word-array model
module tb_mips_mem_responder;
  localparam int WAIT = 2;
  logic clk1 = 1'b0;
  logic rst;
  always #5 clk1 = ~clk1;
  mips_mem_responder_if bus ();
  mips_mem_responder_if bus0 ();
  mips_mem_responder #(.DEPTH(1024), .WAIT(WAIT)) u_dut (.clk1(clk1), .rst(rst), .bus(bus));
  mips_mem_responder #(.DEPTH(1024), .WAIT(0)) u_dut0 (.clk1(clk1), .rst(rst), .bus(bus0));
  typedef struct {
    bit dm;
    bit we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    bit ee;
  } vec_t;
  vec_t tbl [7];
  logic [31:0] m [1024];
  logic [31:0] exp_if, exp_dm;
  int n_cmp = 0;
  int n_bad = 0;
  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hA5A5_0000 | a;
  endfunction
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return a < 32'd1024 ? m[a[9:0]] : 32'h0;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic wait_ack(input bit dm, output int n);
    n = 0;
    do begin
      @(posedge clk1);
      #1;
      n++;
    end while (!(dm ? bus.dm_ack : bus.if_ack) && n < 40);
  endtask
  task automatic wait_ack0(input bit dm, output int n);
    n = 0;
    do begin
      @(posedge clk1);
      #1;
      n++;
    end while (!(dm ? bus0.dm_ack : bus0.if_ack) && n < 40);
  endtask
  task automatic xact(input bit dm, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input bit ee);
    int n;
    if (dm) begin
      bus.dm_req = 1'b1;
      bus.dm_we = we;
      bus.dm_addr = a;
      bus.dm_wdata = wd;
    end else begin
      bus.if_req = 1'b1;
      bus.if_addr = a;
    end
    @(posedge clk1);
    #1;
    chk("busy_after_capture", bus.busy, 1);
    bus.dm_addr = $urandom;
    bus.dm_wdata = $urandom;
    bus.if_addr = $urandom;
    if (dm) bus.dm_we = ~we;
    wait_ack(dm, n);
    chk("latency", n, WAIT + 1);
    bus.dm_req = 1'b0;
    bus.if_req = 1'b0;
    if (dm && we && a < 32'd1024) m[a[9:0]] = wd;
    if (dm && !we) exp_dm = er;
    if (!dm) exp_if = er;
    chk("err", bus.err, ee);
    chk(dm ? "other_ack_if" : "other_ack_dm", dm ? bus.if_ack : bus.dm_ack, 0);
    chk("dm_rdata", bus.dm_rdata, exp_dm);
    chk("if_rdata", bus.if_rdata, exp_if);
    @(posedge clk1);
    #1;
    chk("ack_clear", {bus.dm_ack, bus.if_ack, bus.err, bus.busy}, 0);
  endtask
  initial begin
    int n, acks;
    logic [31:0] a;
    bit dm, we;
    int r;
    exp_if = 0;
    exp_dm = 0;
    rst = 1'b1;
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b0;
    bus.dm_addr = 32'd1024;
    bus.dm_wdata = 0;
    bus.if_req = 1'b1;
    bus.if_addr = 32'd2000;
    bus0.dm_req = 1'b0;
    bus0.dm_we = 1'b0;
    bus0.dm_addr = 0;
    bus0.dm_wdata = 0;
    bus0.if_req = 1'b0;
    bus0.if_addr = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk1);
      #1;
      chk("rst_outputs", {bus.dm_ack, bus.if_ack, bus.err, bus.busy}, 0);
      chk("rst_rdata", bus.dm_rdata | bus.if_rdata, 0);
    end
    rst = 1'b0;
    @(posedge clk1);
    #1;
    chk("rst_release_capture", bus.busy, 1);
    wait_ack(1, n);
    chk("rst_dm_latency", n, WAIT + 1);
    chk("rst_dm_err", bus.err, 1);
    chk("rst_dm_first", bus.if_ack, 0);
    bus.dm_req = 1'b0;
    wait_ack(0, n);
    chk("rst_if_latency", n, WAIT + 3);
    chk("rst_if_err", bus.err, 1);
    bus.if_req = 1'b0;
    @(posedge clk1);
    #1;
    for (int i = 0; i < 32; i++) xact(1, 1, i, pat(i), 0, 0);
    xact(1, 1, 1023, pat(1023), 0, 0);
    tbl[0] = '{1, 1, 32'd5, 32'hDEADBEEF, 32'h0, 0};
    tbl[1] = '{1, 0, 32'd5, 32'h0, 32'hDEADBEEF, 0};
    tbl[2] = '{1, 0, 32'd1024, 32'h0, 32'h0, 1};
    tbl[3] = '{1, 1, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 1};
    tbl[4] = '{1, 0, 32'd1023, 32'h0, 32'hA5A5_03FF, 0};
    tbl[5] = '{0, 0, 32'd5, 32'h0, 32'hDEADBEEF, 0};
    tbl[6] = '{0, 0, 32'd1024, 32'h0, 32'h0, 1};
    for (int i = 0; i < 7; i++) xact(tbl[i].dm, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].er, tbl[i].ee);
    bus.if_req = 1'b1;
    bus.if_addr = 0;
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b0;
    bus.dm_addr = 8;
    wait_ack(1, n);
    chk("cont_dm_latency", n, WAIT + 2);
    chk("cont_dm_rdata", bus.dm_rdata, pat(8));
    chk("cont_if_waits", bus.if_ack, 0);
    bus.dm_req = 1'b0;
    wait_ack(0, n);
    chk("cont_if_gap", n, WAIT + 3);
    chk("cont_if_rdata", bus.if_rdata, pat(0));
    bus.if_req = 1'b0;
    exp_dm = pat(8);
    exp_if = pat(0);
    repeat (4) @(posedge clk1);
    #1;
    chk("if_rdata_hold", bus.if_rdata, exp_if);
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b1;
    bus.dm_addr = 3;
    bus.dm_wdata = 7;
    @(posedge clk1);
    #1;
    @(posedge clk1);
    #1;
    rst = 1'b1;
    bus.dm_req = 1'b0;
    @(posedge clk1);
    #1;
    rst = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    exp_dm = 0;
    exp_if = 0;
    acks = 0;
    repeat (6) begin
      @(posedge clk1);
      #1;
      acks += int'(bus.dm_ack);
    end
    chk("midrst_no_ack", acks, 0);
    xact(1, 0, 3, 0, pat(3), 0);
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      a = r < 7 ? 32'($urandom_range(0, 31)) : r == 7 ? 32'd1023 :
          r == 8 ? 32'd1024 + 32'($urandom_range(0, 5000)) : 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      dm = 1'($urandom_range(0, 1));
      we = dm && 1'($urandom_range(0, 1));
      xact(dm, we, a, $urandom, we ? 32'h0 : model_rd(a), a >= 32'd1024);
    end
    for (int k = 0; k < 3; k++) begin
      bus0.dm_req = 1'b1;
      bus0.dm_we = 1'b1;
      bus0.dm_addr = k;
      bus0.dm_wdata = 32'h1111_0000 + k;
      wait_ack0(1, n);
      chk("w0_store_latency", n, 2);
      bus0.dm_req = 1'b0;
      @(posedge clk1);
      #1;
    end
    bus0.if_req = 1'b1;
    bus0.if_addr = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack0(0, n);
      chk(k == 0 ? "w0_first_fetch" : "w0_fetch_gap", n, k == 0 ? 2 : 3);
      chk("w0_fetch_data", bus0.if_rdata, 32'h1111_0000 + (k < 2 ? k : 2));
      bus0.if_addr = k < 2 ? k + 1 : 2;
    end
    bus0.if_req = 1'b0;
    acks = 0;
    repeat (6) begin
      @(posedge clk1);
      #1;
      acks += int'(bus0.if_ack);
    end
    chk("w0_no_extra_ack", acks, 0);
    chk("w0_rdata_hold", bus0.if_rdata, 32'h1111_0002);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Word-addressed memory responder that serves the MIPS32 pipeline's instruction-fetch and data (LW/SW) accesses over a request/acknowledge handshake. It replaces the processor-internal `Mem` array with a separate slave block. It holds a DEPTH×32 array and arbitrates two requester ports, with data taking fixed priority over fetch. A programmable wait-state count models slow memory.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words; valid addresses are 0..DEPTH-1.
- WAIT, 2, wait-state cycles inserted between request capture and access (0..15).

Ports:
- clk1  in  1  single clock; all state updates on posedge clk1.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack is seen.
- if_addr  in  32  fetch word address (PC value).
- if_ack  out  1  one-cycle fetch response strobe.
- if_rdata  out  32  fetched word; valid while if_ack=1, held until the next if_ack.
- dm_req  in  1  data request; held high until dm_ack is seen.
- dm_we  in  1  1 = store (SW), 0 = load (LW).
- dm_addr  in  32  data word address (EX_MEM_ALUout).
- dm_wdata  in  32  store data (EX_MEM_B).
- dm_ack  out  1  one-cycle data response strobe.
- dm_rdata  out  32  load data; valid while dm_ack=1, held until the next load ack.
- err  out  1  high together with an ack when the serviced address was ≥ DEPTH.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, WAITS, ACCESS, DONE. Reset → IDLE.
- **IDLE**
  - If dm_req=1: capture port=DM, dm_we, dm_addr, dm_wdata.
  - Else if if_req=1: capture port=IF, if_addr, we=0.
  - Else stay in IDLE.
  - On capture: cnt←WAIT; next state is WAITS if WAIT>0, otherwise ACCESS.
- **WAITS**: cnt←cnt-1; go to ACCESS when cnt reaches 1 (i.e. exactly WAIT cycles are spent in WAITS).
- **ACCESS**, single edge, then DONE:
  - Address < DEPTH, read: the selected rdata register ← Mem[addr].
  - Address < DEPTH, write: Mem[addr] ← wdata; dm_rdata is unchanged.
  - Address ≥ DEPTH: read returns 32'h0; write is suppressed; err←1.
  - The selected ack←1.
- **DONE**: the ack and err clear on the next edge; return to IDLE. DONE never samples requests.
- Requester rule: req must be low at the edge after the one that presents ack. Any req still high when IDLE samples is a new request.
- Arbitration is fixed priority, data over fetch. A pending fetch waits while data requests are back-to-back. This is intentional: the MEM-stage access is older than the IF-stage access.
- Captured address, data and we are frozen from capture until DONE; input changes after capture are ignored.
- Only the low ceil(log2(DEPTH)) address bits index the array. The range check uses all 32 bits.
- Memory contents are not reset and are undefined (x) until written.

## Timing
- Request captured at edge t → access and ack-set at edge t+WAIT+1 → ack high for exactly one cycle → ack clears at edge t+WAIT+2 → earliest next capture at edge t+WAIT+3.
- Throughput is one access per WAIT+3 cycles.
- Reset values: if_ack=0, dm_ack=0, err=0, busy=0, if_rdata=0, dm_rdata=0, state=IDLE, cnt=0.
- Reset in any state, including mid-WAITS, abandons the transaction:
  - No ack is issued.
  - A store whose ACCESS edge has not occurred is not written.
  - rst has priority over ACCESS on the same edge.
- Simultaneous if_req and dm_req in IDLE: DM is served first. IF is captured at the IDLE edge after DM's DONE, provided dm_req is low by then.
- A read after a write to the same address returns the new data, because the accesses are serialized.

## Test plan
- **Reset**: assert rst for 3 cycles with both reqs high → all outputs 0, busy=0, no ack. Release rst → DM is captured at the first IDLE edge.
- **Store/load, WAIT=2**:
  - SW addr 5, data 32'hDEADBEEF → dm_ack exactly 3 edges after capture, err=0.
  - Then LW addr 5 → dm_rdata=32'hDEADBEEF with dm_ack.
  - Next capture occurs no earlier than 5 cycles after the previous capture.
- **Contention**: if_req (addr 0) and dm_req (LW addr 8) raised in the same cycle → dm_ack first; if_ack follows exactly WAIT+3 cycles later with Mem[0]. if_rdata stays stable between fetches.
- **Out of range**:
  - LW addr 1024 → dm_rdata=0, err=1 with dm_ack.
  - SW addr 32'hFFFF_FFFF → err=1 and no array word changes; verify that Mem[1023] is unchanged.
- **Reset mid-transaction**: SW addr 3, data 7, with rst pulsed during WAITS → no dm_ack. A later LW addr 3 returns the previous content, not 7.
- **WAIT=0**: back-to-back fetches at addr 0,1,2 → if_ack every 3 cycles with Mem[0..2] in order. A req held one cycle past ack produces a duplicate access, which confirms the requester rule.
